// File: rtl/iic_pkg.sv
// ============================================================================
// Module : iic_pkg -- shared state encoding, quarter phases and byte-list helper
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BYTE  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } iic_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Index of the final byte on the wire for each addressing mode
  localparam logic [1:0] c_last_byte_16 = 2'd3;
  localparam logic [1:0] c_last_byte_8  = 2'd2;

  function automatic logic [7:0] iic_byte_sel(
    input logic       mode,
    input logic [1:0] idx,
    input logic [7:0] slave,
    input logic [7:0] reg_h,
    input logic [7:0] reg_l,
    input logic [7:0] data
  );
    case (idx)
      2'd0:    iic_byte_sel = slave & 8'hFE;
      2'd1:    iic_byte_sel = mode ? reg_h : reg_l;
      2'd2:    iic_byte_sel = mode ? reg_l : data;
      default: iic_byte_sel = data;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/iic_quarter_tick.sv
// ============================================================================
// Module : iic_quarter_tick -- DIV-clock down-counter, 1-clock tick per quarter
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iic_quarter_tick #(
  parameter int DIV = 125
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int                 c_cnt_w  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DIV - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= c_reload;
    end else if (i_restart || (r_cnt == '0)) begin
      r_cnt <= c_reload;
    end else begin
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

  assign o_tick = (r_cnt == '0) && !i_restart;

endmodule

`default_nettype wire

// File: rtl/iic_master_ctrl.sv
// ============================================================================
// Module : iic_master_ctrl -- single-master I2C/SCCB register-write engine
//          Optional ACK checking / early STOP via `IIC_ACK_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iic_master_ctrl
  import iic_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int IIC_FREQ = 100_000,
  parameter int DIV      = CLK_FREQ / (4 * IIC_FREQ)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_iic_mode,
  input  logic [7:0] i_slave_addr,
  input  logic [7:0] i_reg_addr_h,
  input  logic [7:0] i_reg_addr_l,
  input  logic [7:0] i_data_w,
  input  logic       i_iic_write,
  output logic       o_iic_busy,
  output logic       o_nack,
  output logic       o_scl,
  output logic       o_sda_oe,
  input  logic       i_sda
);

  iic_state_t r_state, w_state_nx;
  logic [1:0] r_q;
  logic [2:0] r_bit, w_bit_nx, w_bit_idx;
  logic [1:0] r_byte, w_byte_nx, w_last_byte;
  logic       r_write_d, w_edge, w_accept, w_tick, w_q_end, w_restart, w_abort;
  logic       r_busy, r_scl, r_sda_oe, w_scl, w_sda_oe;
  logic       r_mode;
  logic [7:0] r_slave, r_reg_h, r_reg_l, r_data, w_cur_byte;

  assign w_edge      = i_iic_write && !r_write_d;
  assign w_accept    = (r_state == IDLE) && w_edge;
  assign w_restart   = (r_state == IDLE);
  assign w_q_end     = w_tick && (r_q == Q3);
  assign w_last_byte = r_mode ? c_last_byte_16 : c_last_byte_8;
  assign w_cur_byte  = iic_byte_sel(r_mode, r_byte, r_slave, r_reg_h, r_reg_l, r_data);
  assign w_bit_idx   = 3'd7 - r_bit;

  iic_quarter_tick #(.DIV(DIV)) u_quarter_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

`ifdef IIC_ACK_CHECK_EN
  logic r_nack;

  // Sticky until the next accepted request; a NACK cuts the byte list short
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_nack <= 1'b0;
    end else if (w_accept) begin
      r_nack <= 1'b0;
    end else if ((r_state == ACK) && (r_q == Q2) && w_tick && i_sda) begin
      r_nack <= 1'b1;
    end
  end

  assign w_abort = r_nack;
  assign o_nack  = r_nack;
`else
  logic w_unused_sda;

  assign w_unused_sda = i_sda;
  assign w_abort      = 1'b0;
  assign o_nack       = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit;
    w_byte_nx  = r_byte;
    w_scl      = 1'b1;
    w_sda_oe   = 1'b0;
    case (r_state)
      IDLE: begin
        w_bit_nx  = 3'd0;
        w_byte_nx = 2'd0;
        if (w_edge) w_state_nx = START;
      end
      START: begin
        w_scl    = (r_q != Q3);
        w_sda_oe = (r_q == Q2) || (r_q == Q3);
        if (w_q_end) w_state_nx = BYTE;
      end
      BYTE: begin
        w_scl    = (r_q == Q1) || (r_q == Q2);
        w_sda_oe = !w_cur_byte[w_bit_idx];
        if (w_q_end) begin
          if (r_bit == 3'd7) begin
            w_bit_nx   = 3'd0;
            w_state_nx = ACK;
          end else begin
            w_bit_nx = r_bit + 3'd1;
          end
        end
      end
      ACK: begin
        w_scl = (r_q == Q1) || (r_q == Q2);
        if (w_q_end) begin
          if (w_abort || (r_byte == w_last_byte)) begin
            w_state_nx = STOP;
          end else begin
            w_byte_nx  = r_byte + 2'd1;
            w_state_nx = BYTE;
          end
        end
      end
      STOP: begin
        w_scl    = (r_q != Q0);
        w_sda_oe = (r_q == Q0) || (r_q == Q1);
        if (w_q_end) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Pad outputs are registered so SCL/SDA never glitch on decode
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q       <= Q0;
      r_bit     <= 3'd0;
      r_byte    <= 2'd0;
      r_busy    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_oe  <= 1'b0;
      r_write_d <= 1'b0;
    end else begin
      r_q       <= (r_state == IDLE) ? Q0 : (w_tick ? r_q + 2'd1 : r_q);
      r_bit     <= w_bit_nx;
      r_byte    <= w_byte_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_scl     <= w_scl;
      r_sda_oe  <= w_sda_oe;
      r_write_d <= i_iic_write;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_mode  <= 1'b0;
      r_slave <= 8'h00;
      r_reg_h <= 8'h00;
      r_reg_l <= 8'h00;
      r_data  <= 8'h00;
    end else if (w_accept) begin
      r_mode  <= i_iic_mode;
      r_slave <= i_slave_addr;
      r_reg_h <= i_reg_addr_h;
      r_reg_l <= i_reg_addr_l;
      r_data  <= i_data_w;
    end
  end

  assign o_iic_busy = r_busy;
  assign o_scl      = r_scl;
  assign o_sda_oe   = r_sda_oe;

endmodule

`default_nettype wire

// File: tb/tb_iic_master_ctrl.sv
// ============================================================================
// Module : tb_iic_master_ctrl -- directed self-checking bench for iic_master_ctrl
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iic_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iic_mode = 1'b0;
  logic [7:0] slave_addr = 8'h00, reg_addr_h = 8'h00, reg_addr_l = 8'h00, data_w = 8'h00;
  logic       iic_write = 1'b0;
  logic       iic_busy, nack, scl, sda_oe;
  logic       slave_low = 1'b0;
  logic       sda_line;

  assign sda_line = ~sda_oe & ~slave_low;

  always #5 clk = ~clk;

  iic_master_ctrl #(.CLK_FREQ(4_000_000), .IIC_FREQ(100_000)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_iic_mode   (iic_mode),
    .i_slave_addr (slave_addr),
    .i_reg_addr_h (reg_addr_h),
    .i_reg_addr_l (reg_addr_l),
    .i_data_w     (data_w),
    .i_iic_write  (iic_write),
    .o_iic_busy   (iic_busy),
    .o_nack       (nack),
    .o_scl        (scl),
    .o_sda_oe     (sda_oe),
    .i_sda        (sda_line)
  );

  int total = 0;
  int bad   = 0;

  // Bus monitor + slave model: decodes bytes, START/STOP, busy width; drives ACK per ack_mask
  logic [7:0] ack_mask = 8'h00;
  logic       mon_clr  = 1'b0;
  logic [7:0] m_bytes[8];
  logic       m_ack[8];
  logic [8:0] m_sh;
  int         m_nbit, m_nbytes, m_start, m_stop, m_busy_cnt, m_pulses;
  logic       p_scl, p_sda, p_busy;

  always @(negedge clk) begin
    logic cur_sda;
    cur_sda = ~sda_oe & ~slave_low;
    if (mon_clr) begin
      m_nbit = 0; m_nbytes = 0; m_start = 0; m_stop = 0; m_busy_cnt = 0; m_pulses = 0;
      m_sh = '0; slave_low = 1'b0;
      for (int i = 0; i < 8; i++) begin m_bytes[i] = 8'h00; m_ack[i] = 1'b0; end
      p_scl = scl; p_sda = 1'b1; p_busy = iic_busy;
    end else begin
      if (iic_busy) begin
        m_busy_cnt++;
        if (!p_busy) m_pulses++;
      end
      if (p_scl && scl && p_sda && !cur_sda) begin
        m_start++; m_nbit = 0;
      end else if (p_scl && scl && !p_sda && cur_sda) begin
        m_stop++; m_nbit = 0;
      end else if (!p_scl && scl) begin
        m_sh = {m_sh[7:0], cur_sda};
        m_nbit++;
        if (m_nbit == 9) begin
          if (m_nbytes < 8) begin
            m_bytes[m_nbytes] = m_sh[8:1];
            m_ack[m_nbytes]   = m_sh[0];
          end
          m_nbytes++;
          m_nbit = 0;
        end
      end else if (p_scl && !scl) begin
        slave_low = (m_nbit == 8) && (m_nbytes < 8) && !ack_mask[m_nbytes];
      end
      p_scl = scl; p_sda = ~sda_oe & ~slave_low; p_busy = iic_busy;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mclear();
    mon_clr = 1'b1;
    clks(2);
    mon_clr = 1'b0;
  endtask

  task automatic request(input logic mode, input logic [7:0] sa, input logic [7:0] h,
                         input logic [7:0] l, input logic [7:0] d, input int hold);
    iic_mode = mode; slave_addr = sa; reg_addr_h = h; reg_addr_l = l; data_w = d;
    iic_write = 1'b1;
    clks(hold);
    iic_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (iic_busy && (n < 4000)) begin
      clks(1);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 4000), 32'd1);
    clks(4);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [31:0] exp_bytes);
    check({tag, "_nbytes"}, 32'(m_nbytes), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(m_bytes[i]), 32'(exp_bytes[8*(n-1-i) +: 8]));
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;

    // Reset state, then a quiet idle bus
    mon_clr = 1'b1;
    clks(5);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(iic_busy), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    rst = 1'b1;
    mon_clr = 1'b0;
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      clks(1);
      if (!scl || sda_oe || iic_busy) viol++;
    end
    check("idle_quiet", 32'(viol), 32'd0);

    // 16-bit register write
    mclear();
    request(1'b1, 8'h6C, 8'h30, 8'h35, 8'h21, 10);
    check("w16_busy_high", 32'(iic_busy), 32'd1);
    wait_idle("w16");
    check_bytes("w16", 4, 32'h6C303521);
    check("w16_busy_width", 32'(m_busy_cnt), 32'd1520);
    check("w16_starts", 32'(m_start), 32'd1);
    check("w16_stops", 32'(m_stop), 32'd1);
    check("w16_nack", 32'(nack), 32'd0);

    // 8-bit register write: high address byte must not appear
    mclear();
    request(1'b0, 8'h42, 8'hAA, 8'h12, 8'h80, 10);
    wait_idle("w8");
    check_bytes("w8", 3, 32'h00421280);
    check("w8_busy_width", 32'(m_busy_cnt), 32'd1160);
    check("w8_stops", 32'(m_stop), 32'd1);

    // Edge while busy is dropped; also slave bit0 forced low on the wire
    mclear();
    request(1'b1, 8'h79, 8'h01, 8'h02, 8'h55, 5);
    clks(295);
    request(1'b1, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 5);
    wait_idle("ign");
    check_bytes("ign", 4, 32'h78010255);
    check("ign_pulses", 32'(m_pulses), 32'd1);
    check("ign_busy_width", 32'(m_busy_cnt), 32'd1520);
    clks(20);
    check("ign_no_queue", 32'(iic_busy), 32'd0);

    // Slave NACKs the register-high byte
    mclear();
    ack_mask = 8'h02;
    request(1'b1, 8'h6C, 8'h30, 8'h35, 8'h21, 10);
    wait_idle("nk");
`ifdef IIC_ACK_CHECK_EN
    check("nk_nack", 32'(nack), 32'd1);
    check_bytes("nk", 2, 32'h00006C30);
    check("nk_ack_bit", 32'(m_ack[1]), 32'd1);
    check("nk_busy_width", 32'(m_busy_cnt), 32'd800);
    check("nk_stops", 32'(m_stop), 32'd1);
    mclear();
    ack_mask = 8'h00;
    request(1'b1, 8'h6C, 8'h30, 8'h35, 8'h21, 10);
    check("nk_clear", 32'(nack), 32'd0);
    wait_idle("nk2");
    check("nk2_busy_width", 32'(m_busy_cnt), 32'd1520);
    check("nk2_nack", 32'(nack), 32'd0);
`else
    check("nk_nack_tied", 32'(nack), 32'd0);
    check_bytes("nk", 4, 32'h6C303521);
    check("nk_busy_width", 32'(m_busy_cnt), 32'd1520);
    ack_mask = 8'h00;
`endif

    // Asynchronous reset in the middle of a byte
    mclear();
    request(1'b1, 8'h6C, 8'h30, 8'h35, 8'h21, 10);
    clks(190);
    check("mid_busy", 32'(iic_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("mid_rst_busy", 32'(iic_busy), 32'd0);
    clks(3);
    rst = 1'b1;
    mclear();
    request(1'b0, 8'h42, 8'h00, 8'h12, 8'h80, 10);
    wait_idle("post");
    check_bytes("post", 3, 32'h00421280);
    check("post_busy_width", 32'(m_busy_cnt), 32'd1160);
    check("post_starts", 32'(m_start), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
